// File: rtl/button_event_latch.sv
// Four debounced pushbuttons feeding a one-deep press-event holding register
// that a processor reads through a single 32-bit word.
module button_event_latch #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        red_button,
  input  logic        blue_button,
  input  logic        green_button,
  input  logic        yellow_button,
  input  logic        rd_en,
  output logic [31:0] data_out,
  output logic        event_valid,
  output logic [3:0]  btn_level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Bit index doubles as the color code: 0 red, 1 blue, 2 green, 3 yellow.
  logic [3:0]    w_raw;
  logic [3:0]    r_meta;
  logic [3:0]    r_sync;
  logic [3:0]    r_samp;
  logic [3:0]    r_stable;
  logic [CW-1:0] r_cnt [4];
  logic [3:0]    w_differ;
  logic [3:0]    w_done;
  logic [3:0]    w_rise;
  logic [1:0]    w_new_color;
  logic          w_any_event;
  logic [1:0]    r_color;
  logic          r_valid;
  logic          r_overflow;

  assign w_raw = {yellow_button, green_button, blue_button, red_button};

  // Two-flop synchronizer, then one sample register so a level change lands
  // exactly DEBOUNCE_CYCLES+2 edges after the raw input moves.
  // NOTE: every sequential block uses non-blocking assignments so all flops
  // sample the pre-edge values, regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
      r_samp <= '0;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
      r_samp <= r_sync;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_differ[i] = r_samp[i] ^ r_stable[i];
      w_done[i]   = w_differ[i] && (r_cnt[i] == CNT_MAX);
    end
  end

  // A completed debounce toward 1 is a press; releases are silent.
  assign w_rise      = w_done & r_samp;
  assign w_any_event = |w_rise;

  // NOTE: the counter array is small flop storage, not a RAM, so it is
  // cleared in the reset branch like any other register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stable <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!w_differ[i]) begin
          r_cnt[i] <= '0;
        end else if (w_done[i]) begin
          r_stable[i] <= r_samp[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // NOTE: the default assignment before the loop keeps this purely
  // combinational; without it the encoder would infer a latch.
  always_comb begin
    w_new_color = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_rise[i]) w_new_color = 2'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_color    <= 2'd0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (rd_en) begin
      // A read retires the pending event; a coincident press replaces it.
      r_valid    <= w_any_event;
      r_overflow <= 1'b0;
      if (w_any_event) r_color <= w_new_color;
    end else if (w_any_event) begin
      if (r_valid) begin
        r_overflow <= 1'b1;
      end else begin
        r_color <= w_new_color;
        r_valid <= 1'b1;
      end
    end
  end

  assign data_out    = {28'd0, r_overflow, r_valid, r_color};
  assign event_valid = r_valid;
  assign btn_level   = r_stable;

endmodule

// File: tb/tb_button_event_latch.sv
// Directed bench for button_event_latch with DEBOUNCE_CYCLES=4; expected
// outputs are queued when stimulus is applied and popped when sampled.
module tb_button_event_latch;

  localparam int unsigned DEB = 4;

  logic        clock;
  logic        reset;
  logic        red_button;
  logic        blue_button;
  logic        green_button;
  logic        yellow_button;
  logic        rd_en;
  logic [31:0] data_out;
  logic        event_valid;
  logic [3:0]  btn_level;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        valid;
    logic [3:0]  level;
  } exp_t;

  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_err = 0;

  button_event_latch #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clock        (clock),
    .reset        (reset),
    .red_button   (red_button),
    .blue_button  (blue_button),
    .green_button (green_button),
    .yellow_button(yellow_button),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .event_valid  (event_valid),
    .btn_level    (btn_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_exp(input string tag, input logic [31:0] d,
                          input logic v, input logic [3:0] l);
    exp_t e;
    e.tag = tag; e.data = d; e.valid = v; e.level = l;
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("queue_underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({e.tag, "_data"},  data_out, e.data);
      check({e.tag, "_valid"}, {31'd0, event_valid}, {31'd0, e.valid});
      check({e.tag, "_level"}, {28'd0, btn_level}, {28'd0, e.level});
    end
  endtask

  task automatic expect_now(input string tag, input logic [31:0] d,
                            input logic v, input logic [3:0] l);
    push_exp(tag, d, v, l);
    pop_check();
  endtask

  initial begin
    reset = 1'b1; rd_en = 1'b0;
    red_button = 1'b0; blue_button = 1'b0;
    green_button = 1'b0; yellow_button = 1'b0;
    step(2);
    reset = 1'b0;
    expect_now("reset", 32'h0, 1'b0, 4'b0000);

    // Blue press: event lands at edge DEB+2, not one edge earlier.
    blue_button = 1'b1;
    step(DEB + 2);
    expect_now("blue_early", 32'h0, 1'b0, 4'b0000);
    step(1);
    expect_now("blue_event", 32'h5, 1'b1, 4'b0010);
    rd_en = 1'b1;
    expect_now("blue_read", 32'h5, 1'b1, 4'b0010);
    step(1);
    rd_en = 1'b0;
    expect_now("blue_cleared", 32'h1, 1'b0, 4'b0010);
    blue_button = 1'b0;
    step(DEB + 3);
    expect_now("blue_release", 32'h1, 1'b0, 4'b0000);

    // A 3-cycle glitch is rejected; a 4-cycle pulse is accepted.
    red_button = 1'b1;
    step(DEB - 1);
    red_button = 1'b0;
    step(DEB + 4);
    expect_now("red_glitch", 32'h1, 1'b0, 4'b0000);
    red_button = 1'b1;
    step(DEB);
    red_button = 1'b0;
    step(3);
    expect_now("red_min_pulse", 32'h4, 1'b1, 4'b0001);
    step(DEB + 4);
    expect_now("red_release", 32'h4, 1'b1, 4'b0000);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    expect_now("red_cleared", 32'h0, 1'b0, 4'b0000);

    // Green pending, yellow overflows; read returns pre-clear word.
    green_button = 1'b1;
    step(DEB + 3);
    expect_now("green_event", 32'h6, 1'b1, 4'b0100);
    yellow_button = 1'b1;
    step(DEB + 3);
    expect_now("yellow_overflow", 32'hE, 1'b1, 4'b1100);
    rd_en = 1'b1;
    expect_now("ovf_read", 32'hE, 1'b1, 4'b1100);
    step(1);
    rd_en = 1'b0;
    expect_now("ovf_cleared", 32'h2, 1'b0, 4'b1100);
    green_button = 1'b0; yellow_button = 1'b0;
    step(DEB + 4);
    expect_now("gy_release", 32'h2, 1'b0, 4'b0000);

    // Read with nothing pending has no side effects.
    rd_en = 1'b1;
    expect_now("idle_read", 32'h2, 1'b0, 4'b0000);
    step(1);
    rd_en = 1'b0;
    expect_now("idle_after", 32'h2, 1'b0, 4'b0000);

    // Simultaneous red+yellow from empty: red wins, no overflow.
    red_button = 1'b1; yellow_button = 1'b1;
    step(DEB + 3);
    expect_now("simul_event", 32'h4, 1'b1, 4'b1001);
    red_button = 1'b0; yellow_button = 1'b0;
    step(DEB + 4);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    expect_now("simul_cleared", 32'h0, 1'b0, 4'b0000);

    // Read coincident with a yellow event: new event replaces blue.
    blue_button = 1'b1;
    step(DEB + 3);
    expect_now("blue2_event", 32'h5, 1'b1, 4'b0010);
    yellow_button = 1'b1;
    step(DEB + 2);
    rd_en = 1'b1;
    expect_now("coinc_read", 32'h5, 1'b1, 4'b0010);
    step(1);
    rd_en = 1'b0;
    expect_now("coinc_after", 32'h7, 1'b1, 4'b1010);
    blue_button = 1'b0; yellow_button = 1'b0;
    step(DEB + 4);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    expect_now("coinc_cleared", 32'h3, 1'b0, 4'b0000);

    // Reset mid-debounce with an event pending; held buttons re-press.
    green_button = 1'b1;
    step(DEB + 3);
    expect_now("green2_event", 32'h6, 1'b1, 4'b0100);
    red_button = 1'b1;
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    expect_now("mid_reset", 32'h0, 1'b0, 4'b0000);
    step(DEB + 2);
    expect_now("post_reset_early", 32'h0, 1'b0, 4'b0000);
    step(1);
    expect_now("post_reset_event", 32'h4, 1'b1, 4'b0101);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_event_latch.md
BUTTON_EVENT_LATCH -- requirements
Module: button_event_latch

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), giving the number of consecutive stable-differing cycles needed to accept a level change; legal range 2 to 2^20-1.
REQ-002 The block SHALL have port clock  input  1  system clock, 50 MHz, the only clock.
REQ-003 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port red_button  input  1  raw asynchronous pushbutton, 1 = pressed.
REQ-005 The block SHALL have port blue_button  input  1  raw asynchronous pushbutton, 1 = pressed.
REQ-006 The block SHALL have port green_button  input  1  raw asynchronous pushbutton, 1 = pressed.
REQ-007 The block SHALL have port yellow_button  input  1  raw asynchronous pushbutton, 1 = pressed.
REQ-008 The block SHALL have port rd_en  input  1  memory-mapped read strobe (processor lw to address 7), one cycle per read.
REQ-009 The block SHALL have port data_out  output  32  read word: [31:4]=0, [3]=overflow, [2]=event_valid, [1:0]=color.
REQ-010 The block SHALL have port event_valid  output  1  a captured press is pending.
REQ-011 The block SHALL have port btn_level  output  4  debounced levels {yellow, green, blue, red}.

Function
REQ-012 Color codes SHALL match the LED encoding: 00 red, 01 blue, 10 green, 11 yellow.
REQ-013 Each button SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-014 Per-button debounce: synchronized bit equal to stable level -> counter <= 0; differing and counter < DEBOUNCE_CYCLES-1 -> counter+1; differing and counter == DEBOUNCE_CYCLES-1 -> stable <= synchronized bit, counter <= 0.
REQ-015 Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL NOT change the stable level.
REQ-016 A press event SHALL be the clock edge at which a stable level goes 0->1; 1->0 transitions generate no event.
REQ-017 Latency: with a clean input change just before edge 0, the stable level and any resulting event SHALL update at edge DEBOUNCE_CYCLES+2.
REQ-018 Holding register (event_valid, color): an event with event_valid=0 SHALL load color and set event_valid at that edge.
REQ-019 An event with event_valid=1 and no rd_en SHALL be dropped, set overflow, and leave color unchanged (first press wins).
REQ-020 Simultaneous events on several buttons SHALL load the highest priority (red > blue > green > yellow); if event_valid=0, overflow stays 0.
REQ-021 data_out SHALL be combinational from current registers, so the rd_en cycle returns pre-clear contents.
REQ-022 rd_en with no event in the same cycle SHALL clear event_valid and overflow at that edge; color retains its value.
REQ-023 rd_en coincident with an event SHALL load the new color, keep event_valid=1, and clear overflow (new event wins).
REQ-024 rd_en with event_valid=0 SHALL return event_valid=0 and SHALL have no side effects.
REQ-025 btn_level SHALL equal the four stable levels directly.

Reset
REQ-026 On reset high at a clock edge, the block SHALL clear synchronizer flops, stable levels, counters, color, event_valid and overflow; data_out=0, btn_level=0 from the next cycle.
REQ-027 Reset SHALL take priority over rd_en and events; a debounce in progress SHALL be discarded.
REQ-028 A button held through reset SHALL be treated as a fresh press, producing one event DEBOUNCE_CYCLES+2 edges after reset deasserts.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Reset, then blue high held -> event_valid=1 and data_out=32'h5 after edge 6; btn_level=4'b0010.
REQ-030 Red pulses high for 3 cycles then low -> btn_level stays 0 and event_valid stays 0.
REQ-031 Green press latched, then yellow press -> data_out=32'hE; rd_en -> returns 32'hE, then reads 32'h2 (color kept, valid/overflow cleared).
REQ-032 Red and yellow rise in the same cycle from empty -> data_out=32'h4; overflow=0.
REQ-033 Pending blue (32'h5); rd_en in the same cycle as a yellow event -> after edge, data_out=32'h7.
REQ-034 Pending event, then reset pulse mid-debounce of another button -> all outputs 0, no event until a full new debounce completes.
